kim_fifo_rr_arbiter: RTL and testbench
======================================

// Module: kim_fifo_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one kim_FIFO_top write port between NUM_REQ valid/ready producers.
//  Grants one requester at a time, locks the grant for a burst (until s_last or MAX_BURST beats),
//  then rotates priority. Sits directly in front of the FIFO s_* port; m_* drives the FIFO input.
// PARAMETERS
//  NUM_REQ      4   number of requesters, 2..16
//  REQ_ID_W     2   width of requester index, = clog2(NUM_REQ)
//  DATA_W       32  payload width, matches FIFO_DATA_LENGTH
//  MAX_BURST    8   max beats per grant before forced release, >=1
//  BURST_CNT_W  3   beat counter width, = clog2(MAX_BURST) (min 1)
// PORTS
//  clk      in   1                  single clock, rising edge
//  rst      in   1                  synchronous, active-high reset
//  s_valid  in   NUM_REQ            per-requester valid
//  s_ready  out  NUM_REQ            per-requester ready
//  s_data   in   NUM_REQ*DATA_W     requester i payload at [i*DATA_W +: DATA_W]
//  s_last   in   NUM_REQ            per-requester end-of-burst marker
//  m_valid  out  1                  to FIFO s_valid
//  m_ready  in   1                  from FIFO s_ready
//  m_data   out  DATA_W             to FIFO s_data
//  m_src    out  REQ_ID_W           index of granted requester
//  m_last   out  1                  s_last of granted requester
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=S_IDLE, grant=0, prio_ptr=0, beat_cnt=0.
//   Outputs while rst/S_IDLE: m_valid=0, s_ready=0, m_data=0, m_src=0, m_last=0.
//  Handshake: beat transfers when m_valid & m_ready; requester i beat when s_valid[i] & s_ready[i];
//   both are the same event for the granted i.
//  FSM (2 bits): S_IDLE=2'b00, S_GRANT=2'b01.
//   S_IDLE: if |s_valid -> S_GRANT; grant <= first i with s_valid[i], searching
//     prio_ptr, prio_ptr+1, ... wrapping mod NUM_REQ; beat_cnt <= 0. Else stay.
//   S_GRANT: m_valid=s_valid[grant]; s_ready[grant]=m_ready; other s_ready=0;
//     m_data/m_last/m_src from grant (pure combinational pass-through, 0 cycles latency).
//     On beat: beat_cnt++; if s_last[grant] or beat_cnt==MAX_BURST-1 -> release.
//     Release: state <= S_IDLE, prio_ptr <= (grant+1) mod NUM_REQ, beat_cnt <= 0.
//  Arbitration latency: 1 cycle (S_IDLE bubble) per grant; one idle cycle between bursts.
//  Grant lock: while in S_GRANT, grant never changes, even if s_valid[grant] drops
//   (m_valid follows it low) or higher-priority requests arrive.
//  FIFO full (m_ready=0): hold state, counters and grant; no s_ready asserted.
//  Wrap: prio_ptr NUM_REQ-1 -> 0. beat_cnt never exceeds MAX_BURST-1.
//  MAX_BURST=1: every beat releases. s_last=1 on a beat when beat_cnt==MAX_BURST-1: single release.
//  rst mid-burst: aborts burst, returns to reset values next cycle; no partial state kept.
//  No combinational path from s_valid of non-granted requesters to any output.
// STRUCTURE
//  Shared package kim_fifo_pkg: S_IDLE/S_GRANT encodings, DATA_W default 32, clog2 function.
//  Sub-module kim_rr_picker (combinational): in req[NUM_REQ], ptr[REQ_ID_W];
//   out found, idx[REQ_ID_W] = first set bit at/after ptr with wrap.
//  Top holds FSM, grant/prio_ptr/beat_cnt regs and output mux.
// TESTING
//  Bench drives random s_valid, random m_ready, records m_src/m_data per beat, checks order/count.
//  T1 reset: rst=1 2 cycles with all s_valid=1 -> m_valid=0, s_ready=0000 throughout.
//  T2 single requester: only req2, 3 beats, s_last on 3rd, m_ready=1 -> m_src=2,
//   data 10,11,12 in order, 1 idle cycle, then S_IDLE.
//  T3 rotation: all 4 valid continuously, s_last every beat -> m_src sequence 0,1,2,3,0,1...
//  T4 MAX_BURST=8, req1 never asserts s_last -> grant released after exactly 8 beats,
//   next grant to req2 if valid else wrap search.
//  T5 backpressure: m_ready=0 for 5 cycles mid-burst -> beat_cnt, grant unchanged;
//   no data lost or duplicated; resumes on m_ready=1.
//  T6 rst mid-burst after 3 beats of req3 -> next grant starts search at req0.

Source files
------------

// File: rtl/kim_fifo_pkg.sv
// Shared definitions for the kim FIFO round-robin arbiter: FSM encodings,
// default payload width and a constant-width helper.
package kim_fifo_pkg;

  // Arbiter FSM encodings.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01
  } arb_state_e;

  // Default payload width, matches the FIFO data width.
  localparam int DATA_W_DEF = 32;

  // Bits needed to index 'value' items; never returns less than 1 so that
  // degenerate cases (one item) still get a legal vector width.
  function automatic int kim_clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

endpackage : kim_fifo_pkg

// File: rtl/kim_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit at or
// after ptr, wrapping from NUM_REQ-1 back to 0.
module kim_rr_picker
  import kim_fifo_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int REQ_ID_W = kim_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic                found,
  output logic [REQ_ID_W-1:0] idx
);

  // Scan ptr, ptr+1, ... (mod NUM_REQ); the first hit wins.
  always_comb begin
    int unsigned cand;
    // NOTE: every variable written here gets a value before any branch, so
    // no path can leave it holding its old value and no latch is inferred.
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand[REQ_ID_W-1:0];
      end
    end
  end

endmodule : kim_rr_picker

// File: rtl/kim_fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ
// valid/ready producers. A grant is locked for one burst (until s_last or
// MAX_BURST beats), followed by one idle arbitration cycle, after which the
// search starts just past the previous winner.
module kim_fifo_rr_arbiter
  import kim_fifo_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REQ_ID_W    = kim_clog2(NUM_REQ),
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_BURST   = 8,
  parameter int BURST_CNT_W = kim_clog2(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        s_valid,
  output logic [NUM_REQ-1:0]        s_ready,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]        s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [REQ_ID_W-1:0]       m_src,
  output logic                      m_last
);

  arb_state_e               state_q, state_d;
  logic [REQ_ID_W-1:0]      grant_q, grant_d;
  logic [REQ_ID_W-1:0]      prio_ptr_q, prio_ptr_d;
  logic [BURST_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic                     pick_found;
  logic [REQ_ID_W-1:0]      pick_idx;

  logic [DATA_W-1:0]        req_data [NUM_REQ];
  logic                     g_valid;
  logic                     g_last;
  logic [DATA_W-1:0]        g_data;
  logic                     beat;
  logic                     release_now;

  // The picker only feeds next-state logic, so non-granted s_valid bits
  // never reach an output combinationally.
  kim_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .REQ_ID_W (REQ_ID_W)
  ) u_picker (
    .req   (s_valid),
    .ptr   (prio_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Unpack the flat payload bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i] = s_data[i*DATA_W +: DATA_W];
    end
  end

  // Signals of the currently granted requester and the burst-end decision.
  always_comb begin
    g_valid     = s_valid[grant_q];
    g_last      = s_last[grant_q];
    g_data      = req_data[grant_q];
    beat        = (state_q == S_GRANT) && g_valid && m_ready;
    release_now = g_last || (beat_cnt_q == BURST_CNT_W'(MAX_BURST - 1));
  end

  // Next-state logic: arbitrate in S_IDLE, count beats and release in S_GRANT.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_ptr_d = prio_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_GRANT;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_GRANT: begin
        // Without a beat (FIFO full or requester paused) everything holds.
        if (beat) begin
          if (release_now) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
            prio_ptr_d = (grant_q == REQ_ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output mux: zero-latency pass-through of the granted requester only.
  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = '0;
    m_last  = 1'b0;
    if (!rst && (state_q == S_GRANT)) begin
      m_valid          = g_valid;
      s_ready[grant_q] = m_ready;
      m_data           = g_data;
      m_src            = grant_q;
      m_last           = g_last;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      prio_ptr_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_ptr_q <= prio_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule : kim_fifo_rr_arbiter

// File: tb/tb_kim_fifo_rr_arbiter.sv
// Self-checking bench for kim_fifo_rr_arbiter: per-cycle comparison against a
// behavioural arbiter model, directed bursts with literal expectations, then
// randomized traffic and backpressure.
module tb_kim_fifo_rr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        s_valid;
  logic [NUM_REQ-1:0]        s_ready;
  logic [NUM_REQ*DATA_W-1:0] s_data;
  logic [NUM_REQ-1:0]        s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [DATA_W-1:0]         m_data;
  logic [1:0]                m_src;
  logic                      m_last;

  kim_fifo_rr_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .REQ_ID_W    (2),
    .DATA_W      (DATA_W),
    .MAX_BURST   (MAX_BURST),
    .BURST_CNT_W (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_src   (m_src),
    .m_last  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Producer configuration: beats still to send, s_last period (0 = never),
  // sequence number of the next beat and payload base per requester.
  int          want [NUM_REQ];
  int          blen [NUM_REQ];
  int          seq  [NUM_REQ];
  logic [31:0] base [NUM_REQ];
  bit          held [NUM_REQ];
  int          vprob = 100;
  int          rprob = 100;
  bit          rand_mode = 1'b0;
  logic [NUM_REQ-1:0] acc = '0;
  int          cyc = 0;

  // Log of beats seen at the DUT master port.
  int          log_src  [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];

  // Behavioural model: owner of the port (-1 = arbitrating), beats sent in
  // the current burst, and where the next search starts.
  int own   = -1;
  int nbeat = 0;
  int mptr  = 0;

  // Producers: retire accepted beats, hold valid until accepted, drive data.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        seq[i]++;
        if (want[i] > 0) want[i]--;
        held[i] = 1'b0;
      end
      if (rand_mode && want[i] == 0 && $urandom_range(99) < 20) begin
        want[i] = $urandom_range(12, 1);
        blen[i] = $urandom_range(5, 0);
      end
      s_valid[i] = (want[i] > 0) && (held[i] || $urandom_range(99) < vprob);
      held[i]    = s_valid[i];
      s_last[i]  = (blen[i] != 0) && (((seq[i] + 1) % blen[i]) == 0);
      s_data[i*DATA_W +: DATA_W] = base[i] + seq[i];
    end
    m_ready = ($urandom_range(99) < rprob);
    acc = '0;
  end

  // Compare process: check every output every cycle, then advance the model.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] e_ready;
    logic               e_valid;
    logic               e_last;
    logic [31:0]        e_data;
    logic [1:0]         e_src;
    bit                 hit;
    cyc++;
    e_ready = '0; e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_src = '0;
    if (!rst && own >= 0) begin
      e_valid      = s_valid[own];
      e_ready[own] = m_ready;
      e_data       = s_data[own*DATA_W +: DATA_W];
      e_src        = own[1:0];
      e_last       = s_last[own];
    end
    check("m_valid", m_valid, e_valid);
    check("s_ready", s_ready, e_ready);
    check("m_data",  m_data,  e_data);
    check("m_src",   m_src,   e_src);
    check("m_last",  m_last,  e_last);

    if (m_valid && m_ready) begin
      log_src.push_back(int'(m_src));
      log_data.push_back(m_data);
      log_cyc.push_back(cyc);
    end
    acc = s_valid & s_ready;

    if (rst) begin
      own = -1; nbeat = 0; mptr = 0;
    end else if (own < 0) begin
      hit = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!hit && s_valid[(mptr + k) % NUM_REQ]) begin
          own = (mptr + k) % NUM_REQ;
          hit = 1'b1;
        end
      end
      nbeat = 0;
    end else if (s_valid[own] && m_ready) begin
      nbeat++;
      if (s_last[own] || nbeat == MAX_BURST) begin
        mptr  = (own + 1) % NUM_REQ;
        own   = -1;
        nbeat = 0;
      end
    end
  end

  function automatic bit any_want();
    for (int i = 0; i < NUM_REQ; i++) if (want[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic start_test();
    @(posedge clk); #2;
    rst = 1'b1; rand_mode = 1'b0; vprob = 100; rprob = 100;
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 0; blen[i] = 0; seq[i] = 0; held[i] = 1'b0; base[i] = '0;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    log_src.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (any_want() && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= budget) check("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_beats(input int count, input int budget);
    int n = 0;
    while (log_src.size() < count && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= budget) check("beat_timeout", 1, 0);
  endtask

  int t4_src  [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 1, 1};
  int t4_data [12] = '{100, 101, 102, 103, 104, 105, 106, 107, 200, 201, 108, 109};

  initial begin
    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 100; blen[i] = 0; seq[i] = 0; held[i] = 1'b0; base[i] = '0;
    end

    // T1: reset held with every requester valid.
    repeat (3) begin
      @(negedge clk);
      check("t1_m_valid", m_valid, 1'b0);
      check("t1_s_ready", s_ready, 4'b0000);
    end

    // T2: lone requester 2, three-beat burst.
    start_test();
    base[2] = 10; want[2] = 3; blen[2] = 3;
    drain(50);
    check("t2_count", log_src.size(), 3);
    if (log_src.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        check("t2_src", log_src[k], 2);
        check("t2_data", log_data[k], 10 + k);
      end
      check("t2_back_to_back", log_cyc[2] - log_cyc[0], 2);
    end

    // T3: all four valid, single-beat bursts -> strict rotation.
    start_test();
    for (int i = 0; i < NUM_REQ; i++) begin
      base[i] = 100 * i; want[i] = 6; blen[i] = 1;
    end
    drain(200);
    check("t3_count", log_src.size(), 24);
    if (log_src.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        check("t3_src", log_src[k], k % 4);
        check("t3_data", log_data[k], 100 * (k % 4) + k / 4);
      end
      check("t3_idle_bubble", log_cyc[1] - log_cyc[0], 2);
    end

    // T4: requester 1 never marks s_last -> forced release after 8 beats.
    start_test();
    base[1] = 100; want[1] = 10; blen[1] = 0;
    base[2] = 200; want[2] = 2;  blen[2] = 2;
    drain(200);
    check("t4_count", log_src.size(), 12);
    if (log_src.size() >= 12) begin
      for (int k = 0; k < 12; k++) begin
        check("t4_src", log_src[k], t4_src[k]);
        check("t4_data", log_data[k], t4_data[k]);
      end
    end

    // T5: FIFO full for 5 cycles in the middle of a burst.
    start_test();
    base[0] = 300; want[0] = 6; blen[0] = 6;
    wait_beats(2, 50);
    rprob = 0;
    repeat (6) @(posedge clk);
    rprob = 100;
    drain(100);
    check("t5_count", log_src.size(), 6);
    if (log_src.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check("t5_src", log_src[k], 0);
        check("t5_data", log_data[k], 300 + k);
      end
      check("t5_stall_gap", log_cyc[2] - log_cyc[1], 6);
    end

    // T6: requester 3 keeps the grant after 3 beats (no s_last), a reset
    // aborts it and the next search starts at requester 0.
    start_test();
    base[3] = 400; want[3] = 3; blen[3] = 0;
    drain(50);
    check("t6_first_count", log_src.size(), 3);
    base[0] = 500; want[0] = 1; blen[0] = 1;
    repeat (5) @(negedge clk);
    check("t6_grant_locked", log_src.size(), 3);
    @(posedge clk); #2;
    rst = 1'b1; want[3] = 2;
    @(posedge clk); #2;
    rst = 1'b0;
    log_src.delete(); log_data.delete(); log_cyc.delete();
    drain(50);
    check("t6_count", log_src.size(), 3);
    if (log_src.size() >= 3) begin
      check("t6_src0", log_src[0], 0);
      check("t6_data0", log_data[0], 500);
      check("t6_src1", log_src[1], 3);
      check("t6_data1", log_data[1], 403);
      check("t6_data2", log_data[2], 404);
    end

    // Random traffic and backpressure, with one reset pulse part-way.
    start_test();
    for (int i = 0; i < NUM_REQ; i++) base[i] = i << 24;
    vprob = 60; rprob = 70; rand_mode = 1'b1;
    repeat (1500) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (1500) @(negedge clk);
    check("random_traffic_seen", (log_src.size() > 100), 1'b1);
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_kim_fifo_rr_arbiter
